// File: rtl/div_sequencer.sv
// Iterative restoring divider (DIV/DIVU) with IDLE/BUSY/DONE sequencing.
// Optional macro DIV_EARLY_OUT_EN: finish at once when |dividend| < |divisor|.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             ack,
  input  logic             flush,
  output logic             stall_out,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rmd;

  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH+1:0] w_shift;
  logic             w_ge;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH:0]   w_rem_n;
  logic [WIDTH-1:0] w_q_n;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_last;
  logic             w_idle;
  logic             w_busy;

  assign w_a_mag = (signed_div & dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_b_mag = (signed_div & divisor[WIDTH-1]) ? -divisor : divisor;

  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = w_shift >= {2'b00, r_dvsr};
  assign w_diff  = w_shift[WIDTH:0] - {1'b0, r_dvsr};
  assign w_rem_n = w_ge ? w_diff : w_shift[WIDTH:0];
  assign w_q_n   = {r_q[WIDTH-2:0], w_ge};

  assign w_q_fix = r_neg_q ? -w_q_n : w_q_n;
  assign w_r_fix = r_neg_r ? -w_rem_n[WIDTH-1:0]
                           : w_rem_n[WIDTH-1:0];
  assign w_last  = r_cnt == CW'(WIDTH - 1);

`ifdef DIV_EARLY_OUT_EN
  logic w_early;
  assign w_early = w_a_mag < w_b_mag;
`endif

  assign w_idle = r_state == S_IDLE;
  assign w_busy = r_state == S_BUSY;

  assign stall_out    = resetn & ~flush &
                        ((start & w_idle) | w_busy);
  assign busy         = w_busy;
  assign result_valid = r_state == S_DONE;
  assign quotient     = r_quo;
  assign remainder    = r_rmd;

  // Sequencer: accept, iterate one quotient bit per cycle, hold result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_dvsr  <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_quo   <= '0;
      r_rmd   <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= '0;
            if (divisor == '0) begin
              r_quo   <= '1;
              r_rmd   <= dividend;
              r_state <= S_DONE;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_early) begin
              r_quo   <= '0;
              r_rmd   <= dividend;
              r_state <= S_DONE;
`endif
            end else begin
              r_rem   <= '0;
              r_q     <= w_a_mag;
              r_dvsr  <= w_b_mag;
              r_neg_q <= signed_div &
                         (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              r_neg_r <= signed_div & dividend[WIDTH-1];
              r_state <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_quo   <= w_q_fix;
            r_rmd   <= w_r_fix;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed cases plus random ops
// checked against an arithmetic reference model.
module tb_div_sequencer;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        ack;
  logic        flush;
  logic        stall_out;
  logic        busy;
  logic        result_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_q;
  logic [31:0] last_r;

  div_sequencer #(.WIDTH(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .signed_div   (signed_div),
    .dividend     (dividend),
    .divisor      (divisor),
    .ack          (ack),
    .flush        (flush),
    .stall_out    (stall_out),
    .busy         (busy),
    .result_valid (result_valid),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input  logic [31:0] a,
                                input  logic [31:0] b,
                                input  logic        s,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output int          lat);
    logic [31:0] ma;
    logic [31:0] mb;
    ma = (s && a[31]) ? -a : a;
    mb = (s && b[31]) ? -b : b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      lat = 1;
    end else begin
      q = ma / mb;
      r = ma % mb;
      if (s && (a[31] ^ b[31])) q = -q;
      if (s && a[31]) r = -r;
      lat = 33;
`ifdef DIV_EARLY_OUT_EN
      if (ma < mb) lat = 1;
`endif
    end
  endfunction

  task automatic do_div(input logic [31:0] a,
                        input logic [31:0] b,
                        input logic        s,
                        input int          hold);
    logic [31:0] eq;
    logic [31:0] er;
    int lat;
    model(a, b, s, eq, er, lat);
    @(negedge clk);
    start = 1'b1;
    signed_div = s;
    dividend = a;
    divisor = b;
    ack = 1'b0;
    flush = 1'b0;
    #1 check("stall_c0", stall_out, 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      dividend = $urandom;
      divisor = $urandom;
      signed_div = 1'($urandom_range(0, 1));
      #1;
      if (k < lat) begin
        check("stall_busy", stall_out, 1);
        check("valid_early", result_valid, 0);
        check("busy", busy, 1);
      end
    end
    check("valid", result_valid, 1);
    check("stall_done", stall_out, 0);
    check("busy_done", busy, 0);
    check("quo", quotient, eq);
    check("rem", remainder, er);
    last_q = eq;
    last_r = er;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check("valid_hold", result_valid, 1);
      check("quo_hold", quotient, eq);
    end
    ack = 1'b1;
    @(negedge clk);
    #1;
    check("valid_after_ack", result_valid, 0);
    check("busy_after_ack", busy, 0);
    check("stall_idle_start", stall_out, 1);
    start = 1'b0;
    ack = 1'b0;
    #1 check("stall_idle", stall_out, 0);
  endtask

  initial begin
    resetn = 1'b0;
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    ack = 1'b0;
    flush = 1'b0;
    #3;
    check("rst_stall", stall_out, 0);
    check("rst_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_quo", quotient, 0);
    check("rst_rem", remainder, 0);
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;

    do_div(32'd100, 32'd7, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, 1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_div(32'd5, 32'd0, 1'b0, 2);
    do_div(32'd3, 32'd10, 1'b0, 0);
    do_div(32'hFFFF_FFF9, 32'd10, 1'b1, 0);

    @(negedge clk);
    start = 1'b1;
    signed_div = 1'b0;
    dividend = 32'd100;
    divisor = 32'd7;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    flush = 1'b1;
    #1 check("stall_flush", stall_out, 0);
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    #1;
    check("flush_valid", result_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_stall", stall_out, 0);
    check("flush_quo_kept", quotient, last_q);
    check("flush_rem_kept", remainder, last_r);
    do_div(32'd9, 32'd3, 1'b0, 0);

    @(negedge clk);
    start = 1'b1;
    dividend = 32'hDEAD_BEEF;
    divisor = 32'd3;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_stall", stall_out, 0);
    check("midrst_quo", quotient, 0);
    check("midrst_rem", remainder, 0);
    @(negedge clk);
    resetn = 1'b1;
    start = 1'b0;

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      int mode;
      a = $urandom;
      mode = $urandom_range(0, 3);
      unique case (mode)
        0: b = $urandom;
        1: b = $urandom_range(1, 15);
        2: b = 32'd0;
        default: begin
          b = $urandom | 32'h4000_0000;
          a = $urandom_range(0, 1000);
        end
      endcase
      do_div(a, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
